mem_io_responder: RTL and testbench

- Bus-side responder for the CPU byte-wide memory interface. It answers the CPU's address/data/write-strobe bus.
- Contains 128 KB of byte RAM, a UART-style input FIFO and output FIFO at 0x30000, a cycle counter read at 0x30004, and the stop flag on a write to 0x30004.
- Sits opposite the CPU in the top-level simulation/FPGA harness. It replaces the external RAM plus I/O glue.

---
 rtl/mem_io_responder.sv | 151 +++++++++++++++
 tb/tb_mem_io_responder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// Bus-side responder for the CPU byte-wide memory bus: 128 KB RAM, rx/tx byte FIFOs,
// a free-running cycle counter with read snapshot, and a sticky program-stop flag.
module mem_io_responder #(
    parameter int    RAM_ADDR_W = 17,
    parameter int    FIFO_DEPTH = 8,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] bus_a,
    input  logic [7:0]  bus_din,
    input  logic        bus_wr,
    output logic [7:0]  bus_dout,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt,
    output logic        tx_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam int RAM_BYTES = 2 ** RAM_ADDR_W;

    logic [7:0] ram [RAM_BYTES];
    logic [7:0] rx_mem [FIFO_DEPTH];
    logic [7:0] tx_mem [FIFO_DEPTH];

    logic [7:0]       ram_rdata_q;
    logic             ram_sel_q, ram_sel_d;
    logic [7:0]       io_rdata_q, io_rdata_d;
    logic [PTR_W-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [PTR_W-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [CNT_W-1:0] rx_count_q, rx_count_d, tx_count_q, tx_count_d;
    logic [31:0]      counter_q, counter_d, snapshot_q, snapshot_d;
    logic             halt_q, halt_d, tx_overflow_q, tx_overflow_d;

    logic                  rd_en, wr_en, is_ram, is_io;
    logic [2:0]            io_off;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic                  rx_push, rx_pop, tx_req, tx_full, tx_push, tx_pop;
    logic [7:0]            tx_push_data;
    logic                  unused_addr;

    assign rd_en        = rdy_in & ~bus_wr;
    assign wr_en        = rdy_in & bus_wr & ~halt_q;
    assign is_ram       = ~bus_a[17];
    assign is_io        = bus_a[17] & bus_a[16];
    assign io_off       = bus_a[2:0];
    assign ram_addr     = bus_a[RAM_ADDR_W-1:0];
    assign unused_addr  = ^bus_a[31:18];

    assign rx_ready     = (rx_count_q != FULL_CNT);
    assign rx_push      = rx_valid & rx_ready;
    assign rx_pop       = rd_en & is_io & (io_off == 3'd0) & (rx_count_q != '0);

    assign tx_valid     = (tx_count_q != '0);
    assign tx_data      = tx_mem[tx_rd_ptr_q];
    assign tx_pop       = tx_valid & tx_ready;
    assign tx_full      = (tx_count_q == FULL_CNT);
    assign tx_req       = wr_en & is_io &
                          (((io_off == 3'd0) && (bus_din != 8'h00)) || (io_off == 3'd4));
    // A same-cycle pop never makes room for a push into a full FIFO.
    assign tx_push      = tx_req & ~tx_full;
    assign tx_push_data = (io_off == 3'd4) ? 8'h00 : bus_din;

    assign bus_dout     = ram_sel_q ? ram_rdata_q : io_rdata_q;
    assign halt         = halt_q;
    assign tx_overflow  = tx_overflow_q;

    always_comb begin
        ram_sel_d     = ram_sel_q;
        io_rdata_d    = io_rdata_q;
        snapshot_d    = snapshot_q;
        counter_d     = counter_q + 32'(rdy_in);
        rx_wr_ptr_d   = rx_wr_ptr_q + PTR_W'(rx_push);
        rx_rd_ptr_d   = rx_rd_ptr_q + PTR_W'(rx_pop);
        rx_count_d    = rx_count_q + CNT_W'(rx_push) - CNT_W'(rx_pop);
        tx_wr_ptr_d   = tx_wr_ptr_q + PTR_W'(tx_push);
        tx_rd_ptr_d   = tx_rd_ptr_q + PTR_W'(tx_pop);
        tx_count_d    = tx_count_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
        halt_d        = halt_q | (wr_en & is_io & (io_off == 3'd4));
        tx_overflow_d = tx_overflow_q |
                        (wr_en & is_io & (io_off == 3'd0) & (bus_din != 8'h00) & tx_full);

        if (rd_en) begin
            ram_sel_d  = is_ram;
            io_rdata_d = 8'h00;
            if (is_io) begin
                case (io_off)
                    3'd0: if (rx_count_q != '0) io_rdata_d = rx_mem[rx_rd_ptr_q];
                    3'd4: begin
                        snapshot_d = counter_q;
                        io_rdata_d = counter_q[7:0];
                    end
                    3'd5: io_rdata_d = snapshot_q[15:8];
                    3'd6: io_rdata_d = snapshot_q[23:16];
                    3'd7: io_rdata_d = snapshot_q[31:24];
                    default: io_rdata_d = 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ram_sel_q     <= 1'b0;
            io_rdata_q    <= 8'h00;
            rx_wr_ptr_q   <= '0;
            rx_rd_ptr_q   <= '0;
            rx_count_q    <= '0;
            tx_wr_ptr_q   <= '0;
            tx_rd_ptr_q   <= '0;
            tx_count_q    <= '0;
            counter_q     <= 32'h0;
            snapshot_q    <= 32'h0;
            halt_q        <= 1'b0;
            tx_overflow_q <= 1'b0;
        end else begin
            ram_sel_q     <= ram_sel_d;
            io_rdata_q    <= io_rdata_d;
            rx_wr_ptr_q   <= rx_wr_ptr_d;
            rx_rd_ptr_q   <= rx_rd_ptr_d;
            rx_count_q    <= rx_count_d;
            tx_wr_ptr_q   <= tx_wr_ptr_d;
            tx_rd_ptr_q   <= tx_rd_ptr_d;
            tx_count_q    <= tx_count_d;
            counter_q     <= counter_d;
            snapshot_q    <= snapshot_d;
            halt_q        <= halt_d;
            tx_overflow_q <= tx_overflow_d;
        end
    end

    // RAM kept in its own block without reset so it maps onto block RAM.
    always_ff @(posedge clk_in) begin
        if (!rst_in && wr_en && is_ram) ram[ram_addr] <= bus_din;
        if (!rst_in && rd_en && is_ram) ram_rdata_q <= ram[ram_addr];
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rx_push) rx_mem[rx_wr_ptr_q] <= rx_data;
        if (!rst_in && tx_push) tx_mem[tx_wr_ptr_q] <= tx_push_data;
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: directed scenarios plus a randomized
// run compared against a queue-based behavioural model of the bus and FIFOs.
module tb_mem_io_responder;

    localparam int DEPTH = 8;
    localparam logic [31:0] IDLE_A = 32'h0002_0000;

    logic        clk = 1'b0;
    logic        rst_in = 1'b0, rdy_in = 1'b1, bus_wr = 1'b0;
    logic [31:0] bus_a = IDLE_A;
    logic [7:0]  bus_din = 8'h00, rx_data = 8'h00;
    logic        rx_valid = 1'b0, tx_ready = 1'b0;
    logic [7:0]  bus_dout, tx_data;
    logic        rx_ready, tx_valid, halt, tx_overflow;

    int total = 0;
    int bad = 0;

    // Behavioural model state
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic [7:0]  ram_m[int];
    logic [7:0]  m_dout;
    logic        m_halt, m_ovf;
    logic [31:0] m_cnt, m_snap;

    mem_io_responder dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .bus_a(bus_a),
        .bus_din(bus_din), .bus_wr(bus_wr), .bus_dout(bus_dout),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .halt(halt), .tx_overflow(tx_overflow)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and apply the bus rules to the model.
    task automatic cycle();
        logic [17:0] a;
        logic push_rx, full_tx;
        int k;
        @(posedge clk);
        a = bus_a[17:0];
        k = int'(a[16:0]);
        if (rst_in) begin
            rxq.delete(); txq.delete();
            m_dout = 8'h00; m_halt = 1'b0; m_ovf = 1'b0; m_cnt = 32'h0; m_snap = 32'h0;
        end else begin
            push_rx = rx_valid && (rxq.size() < DEPTH);
            full_tx = (txq.size() == DEPTH);
            if (tx_ready && txq.size() > 0) void'(txq.pop_front());
            if (rdy_in) begin
                if (!bus_wr) begin
                    if (!a[17]) m_dout = ram_m.exists(k) ? ram_m[k] : 8'hxx;
                    else if (!a[16]) m_dout = 8'h00;
                    else begin
                        case (a[2:0])
                            3'd0: m_dout = (rxq.size() > 0) ? rxq.pop_front() : 8'h00;
                            3'd4: begin m_snap = m_cnt; m_dout = m_cnt[7:0]; end
                            3'd5: m_dout = m_snap[15:8];
                            3'd6: m_dout = m_snap[23:16];
                            3'd7: m_dout = m_snap[31:24];
                            default: m_dout = 8'h00;
                        endcase
                    end
                end else if (!m_halt) begin
                    if (!a[17]) ram_m[k] = bus_din;
                    else if (a[16] && a[2:0] == 3'd0 && bus_din != 8'h00) begin
                        if (full_tx) m_ovf = 1'b1; else txq.push_back(bus_din);
                    end else if (a[16] && a[2:0] == 3'd4) begin
                        if (!full_tx) txq.push_back(8'h00);
                        m_halt = 1'b1;
                    end
                end
                m_cnt = m_cnt + 32'd1;
            end
            if (push_rx) rxq.push_back(rx_data);
        end
        #1;
    endtask

    task automatic idle(input int n);
        rdy_in = 1'b1; bus_wr = 1'b0; bus_a = IDLE_A;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic bus_read(input logic [31:0] a);
        rdy_in = 1'b1; bus_wr = 1'b0; bus_a = a;
        cycle();
        bus_a = IDLE_A;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
        rdy_in = 1'b1; bus_wr = 1'b1; bus_a = a; bus_din = d;
        cycle();
        bus_wr = 1'b0; bus_a = IDLE_A;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        idle(2);
        rst_in = 1'b0;
        total++; if (bus_dout !== 8'h00) begin bad++; $display("[TB] FAIL reset_dout: got %02h want 00", bus_dout); end
        total++; if (rx_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_rx_ready: got %b want 1", rx_ready); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_tx_valid: got %b want 0", tx_valid); end
        total++; if (halt !== 1'b0) begin bad++; $display("[TB] FAIL reset_halt: got %b want 0", halt); end
        total++; if (tx_overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf: got %b want 0", tx_overflow); end
    endtask

    task automatic test_ram();
        logic [7:0] r;
        bus_write(32'h0000_1234, 8'hA5);
        total++; if (bus_dout !== 8'h00) begin bad++; $display("[TB] FAIL ram_write_no_dout: got %02h want 00", bus_dout); end
        bus_read(32'h0000_1234);
        total++; if (bus_dout !== 8'hA5) begin bad++; $display("[TB] FAIL ram_read: got %02h want a5", bus_dout); end
        bus_write(32'h0000_1235, 8'h3C);
        total++; if (bus_dout !== 8'hA5) begin bad++; $display("[TB] FAIL ram_dout_hold: got %02h want a5", bus_dout); end
        bus_read(32'h0002_1000);
        total++; if (bus_dout !== 8'h00) begin bad++; $display("[TB] FAIL unmapped_read: got %02h want 00", bus_dout); end
        r = 8'($urandom);
        bus_write(32'h0001_1234, r);
        bus_write(32'h0002_1234, ~r);
        bus_read(32'hABC1_1234);
        total++; if (bus_dout !== r) begin bad++; $display("[TB] FAIL ram_upper_read: got %02h want %02h", bus_dout, r); end
    endtask

    task automatic test_rx();
        rx_valid = 1'b1; rx_data = 8'h41; idle(1);
        rx_data = 8'h42; idle(1);
        rx_valid = 1'b0;
        bus_read(32'h0003_0000);
        total++; if (bus_dout !== 8'h41) begin bad++; $display("[TB] FAIL rx_pop1: got %02h want 41", bus_dout); end
        bus_read(32'h0003_0000);
        total++; if (bus_dout !== 8'h42) begin bad++; $display("[TB] FAIL rx_pop2: got %02h want 42", bus_dout); end
        bus_read(32'h0003_0000);
        total++; if (bus_dout !== 8'h00) begin bad++; $display("[TB] FAIL rx_pop_empty: got %02h want 00", bus_dout); end
        for (int i = 0; i < DEPTH; i++) begin
            rx_valid = 1'b1; rx_data = 8'(8'h60 + i); idle(1);
        end
        total++; if (rx_ready !== 1'b0) begin bad++; $display("[TB] FAIL rx_full_ready: got %b want 0", rx_ready); end
        rx_data = 8'h99; idle(1);
        rx_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus_read(32'h0003_0000);
            total++; if (bus_dout !== 8'(8'h60 + i)) begin bad++; $display("[TB] FAIL rx_drain%0d: got %02h want %02h", i, bus_dout, 8'(8'h60 + i)); end
        end
        bus_read(32'h0003_0000);
        total++; if (bus_dout !== 8'h00) begin bad++; $display("[TB] FAIL rx_ninth_dropped: got %02h want 00", bus_dout); end
        rx_valid = 1'b1; rx_data = 8'h77;
        bus_read(32'h0003_0000);
        rx_valid = 1'b0;
        total++; if (bus_dout !== 8'h00) begin bad++; $display("[TB] FAIL rx_push_pop_empty: got %02h want 00", bus_dout); end
        bus_read(32'h0003_0000);
        total++; if (bus_dout !== 8'h77) begin bad++; $display("[TB] FAIL rx_pushed_kept: got %02h want 77", bus_dout); end
    endtask

    task automatic test_tx();
        tx_ready = 1'b0;
        bus_write(32'h0003_0000, 8'h48);
        bus_write(32'h0003_0000, 8'h00);
        bus_write(32'h0003_0000, 8'h69);
        total++; if (tx_valid !== 1'b1 || tx_data !== 8'h48) begin bad++; $display("[TB] FAIL tx_head: got v=%b d=%02h want v=1 d=48", tx_valid, tx_data); end
        tx_ready = 1'b1; idle(1);
        total++; if (tx_valid !== 1'b1 || tx_data !== 8'h69) begin bad++; $display("[TB] FAIL tx_second: got v=%b d=%02h want v=1 d=69", tx_valid, tx_data); end
        idle(1);
        total++; if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL tx_empty: got %b want 0", tx_valid); end
        tx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) bus_write(32'h0003_0000, 8'(8'h80 + i));
        total++; if (tx_overflow !== 1'b0) begin bad++; $display("[TB] FAIL tx_no_ovf_at_full: got %b want 0", tx_overflow); end
        tx_ready = 1'b1;
        bus_write(32'h0003_0000, 8'hEE);
        total++; if (tx_overflow !== 1'b1) begin bad++; $display("[TB] FAIL tx_ovf: got %b want 1", tx_overflow); end
        for (int i = 1; i < DEPTH; i++) begin
            total++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h80 + i)) begin bad++; $display("[TB] FAIL tx_drain%0d: got v=%b d=%02h want %02h", i, tx_valid, tx_data, 8'(8'h80 + i)); end
            idle(1);
        end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL tx_dropped_not_rescued: got %b want 0", tx_valid); end
    endtask

    task automatic test_counter();
        rst_in = 1'b1; idle(1); rst_in = 1'b0;
        idle(32'h1FF);
        bus_read(32'h0003_0004);
        total++; if (bus_dout !== 8'hFF) begin bad++; $display("[TB] FAIL cnt_b0: got %02h want ff", bus_dout); end
        bus_read(32'h0003_0005);
        total++; if (bus_dout !== 8'h01) begin bad++; $display("[TB] FAIL cnt_b1: got %02h want 01", bus_dout); end
        bus_read(32'h0003_0006);
        total++; if (bus_dout !== 8'h00) begin bad++; $display("[TB] FAIL cnt_b2: got %02h want 00", bus_dout); end
        bus_read(32'h0003_0007);
        total++; if (bus_dout !== 8'h00) begin bad++; $display("[TB] FAIL cnt_b3: got %02h want 00", bus_dout); end
        bus_read(32'h0003_0005);
        total++; if (bus_dout !== 8'h01) begin bad++; $display("[TB] FAIL cnt_snapshot_stable: got %02h want 01", bus_dout); end
        rdy_in = 1'b0; bus_a = 32'h0003_0004;
        for (int i = 0; i < 10; i++) cycle();
        total++; if (bus_dout !== 8'h01) begin bad++; $display("[TB] FAIL cnt_rdy_hold: got %02h want 01", bus_dout); end
        bus_read(32'h0003_0004);
        total++; if (bus_dout !== 8'h04) begin bad++; $display("[TB] FAIL cnt_frozen_b0: got %02h want 04", bus_dout); end
        bus_read(32'h0003_0005);
        total++; if (bus_dout !== 8'h02) begin bad++; $display("[TB] FAIL cnt_frozen_b1: got %02h want 02", bus_dout); end
    endtask

    task automatic test_halt();
        tx_ready = 1'b0;
        bus_write(32'h0000_0010, 8'h5A);
        bus_read(32'h0000_0010);
        total++; if (bus_dout !== 8'h5A) begin bad++; $display("[TB] FAIL halt_pre_ram: got %02h want 5a", bus_dout); end
        bus_write(32'h0003_0004, 8'h77);
        total++; if (halt !== 1'b1) begin bad++; $display("[TB] FAIL halt_set: got %b want 1", halt); end
        total++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin bad++; $display("[TB] FAIL halt_tx_zero: got v=%b d=%02h want v=1 d=00", tx_valid, tx_data); end
        bus_write(32'h0000_0010, 8'h11);
        bus_read(32'h0000_0010);
        total++; if (bus_dout !== 8'h5A) begin bad++; $display("[TB] FAIL halt_ram_protect: got %02h want 5a", bus_dout); end
        bus_write(32'h0003_0000, 8'h55);
        tx_ready = 1'b1; idle(1);
        total++; if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL halt_tx_blocked: got %b want 0", tx_valid); end
        total++; if (halt !== 1'b1) begin bad++; $display("[TB] FAIL halt_sticky: got %b want 1", halt); end
    endtask

    task automatic test_reset_mid_read();
        rst_in = 1'b1; idle(1); rst_in = 1'b0;
        tx_ready = 1'b0;
        bus_write(32'h0003_0000, 8'h44);
        bus_write(32'h0003_0004, 8'h01);
        rx_valid = 1'b1; rx_data = 8'h33; idle(1);
        rx_data = 8'h34; idle(1);
        rx_valid = 1'b0;
        bus_read(32'h0003_0000);
        total++; if (bus_dout !== 8'h33) begin bad++; $display("[TB] FAIL rst_pre_read: got %02h want 33", bus_dout); end
        rst_in = 1'b1; bus_a = 32'h0003_0000; cycle(); rst_in = 1'b0;
        total++; if (bus_dout !== 8'h00) begin bad++; $display("[TB] FAIL rst_mid_dout: got %02h want 00", bus_dout); end
        total++; if (rx_ready !== 1'b1 || tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_fifo: got rdy=%b v=%b want 1 0", rx_ready, tx_valid); end
        total++; if (halt !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_halt: got %b want 0", halt); end
        bus_read(32'h0003_0000);
        total++; if (bus_dout !== 8'h00) begin bad++; $display("[TB] FAIL rst_rx_lost: got %02h want 00", bus_dout); end
    endtask

    task automatic test_random();
        logic [16:0] addrs[16];
        logic [31:0] r;
        logic [17:0] a;
        int op;
        rst_in = 1'b1; idle(1); rst_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            r = $urandom;
            addrs[i] = {r[16], 8'h02, r[3:0], 4'(i)};
            bus_write({15'h0, addrs[i]}, r[31:24]);
        end
        for (int i = 0; i < 600; i++) begin
            r = $urandom;
            rdy_in = ($urandom_range(0, 9) != 0);
            rx_valid = $urandom_range(0, 1);
            rx_data = 8'($urandom);
            tx_ready = ($urandom_range(0, 2) == 0);
            op = $urandom_range(0, 9);
            bus_wr = 1'b0;
            bus_din = 8'($urandom);
            case (op)
                0, 1: a = {1'b0, addrs[r[3:0]]};
                2: begin a = {1'b0, addrs[r[3:0]]}; bus_wr = 1'b1; end
                3: a = {2'b10, r[15:0]};
                4, 5: a = 18'h30000;
                6: a = 18'h30004 + 18'(r[1:0]);
                7: a = 18'h30000 + 18'($urandom_range(1, 3));
                8: begin a = 18'h30000; bus_wr = 1'b1; if (r[5:4] == 2'b00) bus_din = 8'h00; end
                default: begin a = (i > 550) ? 18'h30004 : {2'b10, r[15:0]}; bus_wr = 1'b1; end
            endcase
            bus_a = {r[31:18], a};
            cycle();
            total++; if (bus_dout !== m_dout) begin bad++; $display("[TB] FAIL rnd_dout@%0d: got %02h want %02h", i, bus_dout, m_dout); end
            total++; if (rx_ready !== (rxq.size() < DEPTH)) begin bad++; $display("[TB] FAIL rnd_rx_ready@%0d: got %b want %b", i, rx_ready, rxq.size() < DEPTH); end
            total++; if (tx_valid !== (txq.size() > 0)) begin bad++; $display("[TB] FAIL rnd_tx_valid@%0d: got %b want %b", i, tx_valid, txq.size() > 0); end
            if (txq.size() > 0) begin
                total++; if (tx_data !== txq[0]) begin bad++; $display("[TB] FAIL rnd_tx_data@%0d: got %02h want %02h", i, tx_data, txq[0]); end
            end
            total++; if (halt !== m_halt || tx_overflow !== m_ovf) begin bad++; $display("[TB] FAIL rnd_flags@%0d: got h=%b o=%b want h=%b o=%b", i, halt, tx_overflow, m_halt, m_ovf); end
        end
        rx_valid = 1'b0; tx_ready = 1'b0; idle(1);
    endtask

    initial begin
        test_reset();
        test_ram();
        test_rx();
        test_tx();
        test_counter();
        test_halt();
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
